pipe_stall_ctrl: RTL

Central hazard and stall controller for the five-stage RISC-V pipeline. It arbitrates between data-memory-miss stalls and load-use hazards, and produces the freeze, bubble and flush controls for PC, IF/ID, ID/EX and EX/MEM/MEM/WB. It also runs the data-memory request/acknowledge handshake for the instruction in the MEM stage and keeps a saturating stall-cycle counter. Sits beside the pipeline registers; its `Data_Stall_o` drives every pipeline register's `Data_Stall_i`.

---
 rtl/pipe_stall_ctrl_pkg.sv | 20 ++
 rtl/pipe_stall_ctrl_hazard_detect.sv | 28 ++
 rtl/pipe_stall_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl_pkg
// Purpose  : Shared constants for the pipeline stall controller: register
//            index width and the memory-handshake FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

    // Architectural register index width (x0..x31).
    localparam int c_REG_SIZE = 5;

    // Memory-handshake FSM encoding.
    localparam int         c_STATE_W   = 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_ERR    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use hazard compare between the load in EX and
//            the source registers of the instruction in ID.
// Ports    : IDEX_MemRead_i - EX-stage instruction is a load
//            IDEX_rd_i      - EX-stage destination register
//            IFID_rs1_i/rs2 - ID-stage source registers
//            hazard_o       - ID instruction needs the load result next cycle
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic                  IDEX_MemRead_i,
    input  logic [c_REG_SIZE-1:0] IDEX_rd_i,
    input  logic [c_REG_SIZE-1:0] IFID_rs1_i,
    input  logic [c_REG_SIZE-1:0] IFID_rs2_i,
    output logic                  hazard_o
);

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign hazard_o = IDEX_MemRead_i
                    & (IDEX_rd_i != '0)
                    & ((IDEX_rd_i == IFID_rs1_i) | (IDEX_rd_i == IFID_rs2_i));

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : Central hazard/stall controller for the five-stage pipeline.
//            Runs the data-memory request/ack handshake for the MEM-stage
//            instruction (with timeout to a sticky error state), arbitrates
//            memory freeze against load-use bubbles, and counts stall cycles.
// Ports    : clk_i, rst_i (sync, active-high)
//            EXMEM_MemRead_i/MemWrite_i, mem_ack_i  - MEM-stage handshake in
//            IDEX_MemRead_i, IDEX_rd_i, IFID_rs1_i/rs2_i - load-use compare
//            Branch_Taken_i                         - ID branch resolution
//            mem_req_o, Data_Stall_o, PC_Write_o, IFID_Write_o,
//            IDEX_Bubble_o, IFID_Flush_o            - pipeline controls
//            err_o                                  - sticky memory timeout
//            stall_cnt_o                            - saturating stall count
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  EXMEM_MemRead_i,
    input  logic                  EXMEM_MemWrite_i,
    input  logic                  mem_ack_i,
    input  logic                  IDEX_MemRead_i,
    input  logic [c_REG_SIZE-1:0] IDEX_rd_i,
    input  logic [c_REG_SIZE-1:0] IFID_rs1_i,
    input  logic [c_REG_SIZE-1:0] IFID_rs2_i,
    input  logic                  Branch_Taken_i,
    output logic                  mem_req_o,
    output logic                  Data_Stall_o,
    output logic                  PC_Write_o,
    output logic                  IFID_Write_o,
    output logic                  IDEX_Bubble_o,
    output logic                  IFID_Flush_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int                c_WAIT_W  = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(TIMEOUT);

    logic [c_STATE_W-1:0] r_state;
    logic [c_WAIT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic w_mem_op;
    logic w_hazard;
    logic w_req;
    logic w_stall;

    assign w_mem_op = EXMEM_MemRead_i | EXMEM_MemWrite_i;

    hazard_detect u_hazard_detect (
        .IDEX_MemRead_i (IDEX_MemRead_i),
        .IDEX_rd_i      (IDEX_rd_i),
        .IFID_rs1_i     (IFID_rs1_i),
        .IFID_rs2_i     (IFID_rs2_i),
        .hazard_o       (w_hazard)
    );

    // Handshake outputs depend on the current state and ack directly, so the
    // freeze drops in the same cycle the memory acknowledges.
    always_comb begin
        w_req   = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_req   = w_mem_op;
                w_stall = w_mem_op & ~mem_ack_i;
            end
            c_ST_WAIT: begin
                w_req   = 1'b1;
                w_stall = ~mem_ack_i;
            end
            c_ST_ERR: begin
                w_req   = 1'b0;
                w_stall = 1'b1;
            end
            default: begin
                w_req   = 1'b0;
                w_stall = 1'b1;
            end
        endcase
    end

    // Freeze outranks the load-use bubble; a taken branch is only honoured
    // when neither applies, since a bubbled branch re-resolves next cycle.
    always_comb begin
        mem_req_o     = w_req;
        Data_Stall_o  = w_stall;
        PC_Write_o    = ~w_stall & ~w_hazard;
        IFID_Write_o  = ~w_stall & ~w_hazard;
        IDEX_Bubble_o = ~w_stall &  w_hazard;
        IFID_Flush_o  = ~w_stall & ~w_hazard & Branch_Taken_i;
    end

    assign err_o       = (r_state == c_ST_ERR);
    assign stall_cnt_o = r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_mem_op && !mem_ack_i) begin
                        r_state    <= c_ST_WAIT;
                        r_wait_cnt <= c_WAIT_W'(1);
                    end
                end
                c_ST_WAIT: begin
                    // Ack takes precedence over a simultaneous timeout.
                    if (mem_ack_i) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_wait_cnt == c_TIMEOUT) begin
                        r_state <= c_ST_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                c_ST_ERR: begin
                    r_state <= c_ST_ERR;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase

            if ((w_stall || w_hazard) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
